// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for lock with timeout and bounded retries, and
// qualifies lock as stable before releasing the downstream system reset.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int COUNT_W             = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam logic [COUNT_W-1:0] RST_LAST     = COUNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] STABLE_LAST  = COUNT_W'(STABLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;
  localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic               sync1;
  logic               locked_s;
  state_t             state;
  state_t             state_next;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_next;
  logic [3:0]         retry_next;
  logic [3:0]         retry_inc;
  logic               lost_next;

  assign retry_inc = retry_count + 4'd1;

  always_comb begin
    state_next = state;
    count_next = (count == COUNT_MAX) ? count : count + COUNT_W'(1);
    retry_next = retry_count;
    lost_next  = 1'b0;
    if (restart) begin
      state_next = S_RESET_PLL;
      count_next = '0;
      retry_next = '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (count >= RST_LAST) begin
            state_next = S_WAIT_LOCK;
            count_next = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = S_STABLE;
            count_next = '0;
          end else if (count >= TIMEOUT_LAST) begin
            count_next = '0;
            retry_next = retry_inc;
            state_next = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
          end
        end
        S_STABLE: begin
          // A drop during qualification is not a failed attempt; only the timeout counts.
          if (!locked_s) begin
            state_next = S_WAIT_LOCK;
            count_next = '0;
          end else if (count >= STABLE_LAST) begin
            state_next = S_RUN;
            count_next = '0;
            retry_next = '0;
          end
        end
        S_RUN: begin
          count_next = '0;
          if (!locked_s) begin
            state_next = S_RESET_PLL;
            lost_next  = 1'b1;
          end
        end
        S_FAIL: begin
          count_next = '0;
        end
        default: begin
          state_next = S_RESET_PLL;
          count_next = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      locked_s    <= 1'b0;
      state       <= S_RESET_PLL;
      count       <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      sync1       <= locked_in;
      locked_s    <= sync1;
      state       <= state_next;
      count       <= count_next;
      retry_count <= retry_next;
      pll_rst     <= (state_next == S_RESET_PLL) || (state_next == S_FAIL);
      sys_rst     <= (state_next != S_RUN);
      ready       <= (state_next == S_RUN);
      fail        <= (state_next == S_FAIL);
      lock_lost   <= lost_next;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table for the lock sequences,
// hand-written async-reset and priority cases, then random lock traffic vs a model.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE = 4;
  localparam int TIMEOUT   = 100;
  localparam int STABLE    = 8;
  localparam int MAXR      = 2;
  localparam int CW        = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked_in;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_count;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (RST_PULSE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .STABLE_CYCLES      (STABLE),
    .MAX_RETRIES        (MAXR),
    .COUNT_W            (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked_in  (locked_in),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  typedef struct {
    logic       li;
    logic       rs;
    int         reps;
    logic [8:0] exp;
  } vec_t;

  vec_t rows[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic use_model = 1'b0;

  // Output bundle: {pll_rst, sys_rst, ready, fail, lock_lost, retry_count}
  function automatic logic [8:0] o_rst(int rc);
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'(rc)};
  endfunction
  function automatic logic [8:0] o_wait(int rc);
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(rc)};
  endfunction
  function automatic logic [8:0] o_run();
    return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
  endfunction
  function automatic logic [8:0] o_lost();
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
  endfunction
  function automatic logic [8:0] o_fail();
    return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'(MAXR)};
  endfunction

  function automatic logic [8:0] actual();
    return {pll_rst, sys_rst, ready, fail, lock_lost, retry_count};
  endfunction

  function automatic void add(logic li, logic rs, int reps, logic [8:0] e);
    vec_t v;
    v.li = li; v.rs = rs; v.reps = reps; v.exp = e;
    rows.push_back(v);
  endfunction

  function automatic void check(string name, logic [8:0] got, logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %b required %b (pll,sys,rdy,fail,lost,retry)", name, got, exp);
    end
  endfunction

  // Reference model: phase plus cycles spent in it, lock seen through a 2-deep history.
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FAIL = 4;
  int   ph;
  int   age;
  int   retries;
  logic lost;
  logic hist[$];

  function automatic void model_reset();
    ph = P_RST; age = 0; retries = 0; lost = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endfunction

  function automatic void model_step(logic li, logic rs);
    logic ls;
    ls = hist[hist.size()-2];
    hist.push_back(li);
    if (hist.size() > 4) void'(hist.pop_front());
    lost = 1'b0;
    if (rs) begin
      ph = P_RST; age = 0; retries = 0;
    end else begin
      case (ph)
        P_RST: begin
          age++;
          if (age == RST_PULSE) begin ph = P_WAIT; age = 0; end
        end
        P_WAIT: begin
          if (ls) begin
            ph = P_STB; age = 0;
          end else begin
            age++;
            if (age == TIMEOUT) begin
              retries++;
              age = 0;
              ph = (retries == MAXR) ? P_FAIL : P_RST;
            end
          end
        end
        P_STB: begin
          if (!ls) begin
            ph = P_WAIT; age = 0;
          end else begin
            age++;
            if (age == STABLE) begin ph = P_RUN; age = 0; retries = 0; end
          end
        end
        P_RUN: begin
          if (!ls) begin ph = P_RST; age = 0; lost = 1'b1; end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [8:0] model_out();
    return {ph == P_RST || ph == P_FAIL, ph != P_RUN, ph == P_RUN, ph == P_FAIL,
            lost, 4'(retries)};
  endfunction

  task automatic tick(input logic li, input logic rs);
    locked_in = li;
    restart   = rs;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(li, rs);
    #1;
    if (use_model) check("model", actual(), model_out());
  endtask

  task automatic run_rows(input int lo, input int hi, input string name);
    for (int i = lo; i < hi; i++) begin
      for (int r = 0; r < rows[i].reps; r++) begin
        tick(rows[i].li, rows[i].rs);
        check($sformatf("%s row %0d rep %0d", name, i, r), actual(), rows[i].exp);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; locked_in = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", actual(), o_rst(0));
    rst = 1'b0;
  endtask

  int   b1, b3, b4, b2, b5, b6a, b6b, b_end;
  logic v;
  int   len;
  int   cyc;

  initial begin
    // Test 1: lock 10 cycles after pll_rst falls
    b1 = rows.size();
    add(0, 0, 3, o_rst(0));
    add(0, 0, 11, o_wait(0));
    add(1, 0, 10, o_wait(0));
    add(1, 0, 4, o_run());
    // Test 3: 3-cycle lock drop in RUN
    b3 = rows.size();
    add(0, 0, 2, o_run());
    add(0, 0, 1, o_lost());
    add(1, 0, 3, o_rst(0));
    add(1, 0, 1, o_wait(0));
    add(1, 0, 8, o_wait(0));
    add(1, 0, 2, o_run());
    // Test 4: restart, then a 2-cycle drop in STABLE restarts qualification
    b4 = rows.size();
    add(1, 1, 1, o_rst(0));
    add(1, 0, 3, o_rst(0));
    add(1, 0, 1, o_wait(0));
    add(1, 0, 4, o_wait(0));
    add(0, 0, 2, o_wait(0));
    add(1, 0, 2, o_wait(0));
    add(1, 0, 8, o_wait(0));
    add(1, 0, 2, o_run());
    // Test 2: never lock, two attempts then FAIL held
    b2 = rows.size();
    add(0, 1, 1, o_rst(0));
    add(0, 0, 3, o_rst(0));
    add(0, 0, 100, o_wait(0));
    add(0, 0, 4, o_rst(1));
    add(0, 0, 100, o_wait(1));
    add(0, 0, 40, o_fail());
    // Test 5: restart out of FAIL, then normal lock
    b5 = rows.size();
    add(0, 1, 1, o_rst(0));
    add(1, 0, 3, o_rst(0));
    add(1, 0, 1, o_wait(0));
    add(1, 0, 8, o_wait(0));
    add(1, 0, 2, o_run());
    // Test 6: walk into STABLE, then (after async reset) a clean full sequence
    b6a = rows.size();
    add(1, 0, 3, o_rst(0));
    add(1, 0, 1, o_wait(0));
    add(1, 0, 3, o_wait(0));
    b6b = rows.size();
    add(1, 0, 3, o_rst(0));
    add(1, 0, 1, o_wait(0));
    add(1, 0, 8, o_wait(0));
    add(1, 0, 2, o_run());
    b_end = rows.size();

    do_reset();
    run_rows(b1, b3, "t1_lock");
    run_rows(b3, b4, "t3_drop_run");
    run_rows(b4, b2, "t4_drop_stable");
    run_rows(b2, b5, "t2_no_lock");
    run_rows(b5, b6a, "t5_restart_fail");

    do_reset();
    run_rows(b6a, b6b, "t6_pre");
    // Assert rst between edges; outputs must respond before the next edge.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", actual(), o_rst(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("async_rst_held", actual(), o_rst(0));
    rst = 1'b0;
    run_rows(b6b, b_end, "t6_post");

    // restart wins over a lock drop seen in RUN: no lock_lost pulse
    tick(1'b0, 1'b0);
    check("prio_run_a", actual(), o_run());
    tick(1'b0, 1'b0);
    check("prio_run_b", actual(), o_run());
    tick(1'b0, 1'b1);
    check("restart_priority", actual(), o_rst(0));

    // Random lock traffic with occasional restarts against the model
    use_model = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) len = $urandom_range(1, 60);
      else if ($urandom_range(0, 7) == 0) len = $urandom_range(100, 260);
      else len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) tick(v, $urandom_range(0, 299) == 0);
      cyc += len;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
